// File: rtl/sensor_responder_if.sv
// Serial sensor bus plus sample-feed handshake between an initiator/producer
// and the sensor_responder target.
interface sensor_responder_if;
    logic       ncs;
    logic       scl;
    logic       sda_out;
    logic       sda_oe;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       frame_done;
    logic       frame_abort;
    logic       underrun;
    logic       busy;

    modport master (
        output ncs, scl, sample_data, sample_valid,
        input  sda_out, sda_oe, sample_ready, frame_done, frame_abort, underrun, busy
    );

    modport slave (
        input  ncs, scl, sample_data, sample_valid,
        output sda_out, sda_oe, sample_ready, frame_done, frame_abort, underrun, busy
    );
endinterface

// File: rtl/sensor_responder.sv
// Serial sensor target: shifts one 16-bit frame per chip-select window, fed
// from a one-entry holding register that resends the last byte on underrun.
module sensor_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int LEAD_ZEROS  = 3
) (
    input  logic               clk,
    input  logic               rst,
    sensor_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   ncs_sync_q;
    logic [SYNC_STAGES-1:0]   scl_sync_q;
    logic                     ncs_prev_q;
    logic                     scl_prev_q;
    logic [15:0]              shift_q, shift_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [7:0]               hold_q, hold_d;
    logic                     hold_valid_q, hold_valid_d;
    logic [7:0]               last_q, last_d;
    logic                     sda_out_q, sda_oe_q, busy_q, ready_q;
    logic                     done_q, abort_q, underrun_q;

    logic                     ncs_fall_s, ncs_rise_s, scl_fall_s;
    logic                     accept_s, load_s;
    logic                     done_s, abort_s, underrun_s;
    logic [7:0]               load_byte_s;

    // Bit 0 of the frame goes out first: leading zeros, data MSB first, trailing zeros.
    function automatic logic [15:0] build_frame(input logic [7:0] b);
        logic [15:0] f;
        f = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            f[LEAD_ZEROS + k] = b[7 - k];
        end
        return f;
    endfunction

    assign ncs_fall_s = ncs_prev_q & ~ncs_sync_q[SYNC_STAGES-1];
    assign ncs_rise_s = ~ncs_prev_q & ncs_sync_q[SYNC_STAGES-1];
    assign scl_fall_s = scl_prev_q & ~scl_sync_q[SYNC_STAGES-1];
    assign accept_s   = bus.sample_valid & ~hold_valid_q;

    // Next-state, frame shifting and holding-register bookkeeping.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        last_d       = last_q;
        load_s       = 1'b0;
        load_byte_s  = last_q;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        underrun_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ncs_fall_s) begin
                    state_d = ACTIVE;
                    load_s  = 1'b1;
                    cnt_d   = 5'd0;
                    if (hold_valid_q) begin
                        load_byte_s = hold_q;
                    end else begin
                        load_byte_s = last_q;
                        underrun_s  = 1'b1;
                    end
                    shift_d = build_frame(load_byte_s);
                    last_d  = load_byte_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (ncs_rise_s) begin
                    state_d = IDLE;
                    abort_s = 1'b1;
                end else if (scl_fall_s) begin
                    shift_d = {1'b0, shift_q[15:1]};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_d = DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            DONE: begin
                if (ncs_rise_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A same-cycle accept wins: the load already used the old contents.
        if (accept_s) begin
            hold_d       = bus.sample_data;
            hold_valid_d = 1'b1;
        end else if (load_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // State, synchronizers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ncs_sync_q   <= {SYNC_STAGES{1'b1}};
            scl_sync_q   <= {SYNC_STAGES{1'b0}};
            ncs_prev_q   <= 1'b1;
            scl_prev_q   <= 1'b0;
            shift_q      <= 16'h0000;
            cnt_q        <= 5'd0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            last_q       <= 8'h00;
            sda_out_q    <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ncs_sync_q   <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
            scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
            ncs_prev_q   <= ncs_sync_q[SYNC_STAGES-1];
            scl_prev_q   <= scl_sync_q[SYNC_STAGES-1];
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            last_q       <= last_d;
            sda_out_q    <= (state_d == ACTIVE) & shift_d[0];
            sda_oe_q     <= (state_d != IDLE);
            busy_q       <= (state_d != IDLE);
            ready_q      <= ~hold_valid_d;
            done_q       <= done_s;
            abort_q      <= abort_s;
            underrun_q   <= underrun_s;
        end
    end

    assign bus.sda_out      = sda_out_q;
    assign bus.sda_oe       = sda_oe_q;
    assign bus.busy         = busy_q;
    assign bus.sample_ready = ready_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_abort  = abort_q;
    assign bus.underrun     = underrun_q;

endmodule

// File: tb/tb_sensor_responder.sv
// Directed bench for sensor_responder: expected wire bits are queued when a
// frame is driven and popped at each scl rising edge.
module tb_sensor_responder;
    localparam int LZ = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_done;
    int   n_abort;
    int   n_under;
    logic exp_q[$];

    sensor_responder_if bus_if ();

    sensor_responder #(.SYNC_STAGES(2), .LEAD_ZEROS(LZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors, counted away from the active edge.
    always @(negedge clk) begin
        if (bus_if.frame_done)  n_done  = n_done + 1;
        if (bus_if.frame_abort) n_abort = n_abort + 1;
        if (bus_if.underrun)    n_under = n_under + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k >= LZ && k < LZ + 8) return b[7 - (k - LZ)];
        return 1'b0;
    endfunction

    task automatic accept_byte(input logic [7:0] b);
        bus_if.sample_data  = b;
        bus_if.sample_valid = 1'b1;
        wait_clk(1);
        bus_if.sample_valid = 1'b0;
        wait_clk(2);
    endtask

    // Drives ncs low, n scl cycles (50 clk period), optionally releases ncs.
    task automatic run_frame(input logic [7:0] b, input int n, input bit release_ncs);
        logic e;
        for (int k = 0; k < n; k++) exp_q.push_back(exp_bit(b, k));
        bus_if.ncs = 1'b0;
        wait_clk(25);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                check("sda_oe_active", bus_if.sda_oe, 1);
                check("busy_active", bus_if.busy, 1);
            end
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 0, 1);
                e = 1'b0;
            end else begin
                e = exp_q.pop_front();
            end
            check("sda_bit", bus_if.sda_out, e);
            bus_if.scl = 1'b1;
            wait_clk(25);
            bus_if.scl = 1'b0;
            wait_clk(25);
        end
        if (release_ncs) begin
            bus_if.ncs = 1'b1;
            wait_clk(10);
        end
    endtask

    initial begin
        int d_done, d_abort, d_under;
        n_cmp = 0; n_err = 0; n_done = 0; n_abort = 0; n_under = 0;
        rst = 1'b1;
        bus_if.ncs = 1'b1;
        bus_if.scl = 1'b0;
        bus_if.sample_data = 8'h00;
        bus_if.sample_valid = 1'b0;
        wait_clk(5);
        check("rst_ready", bus_if.sample_ready, 1);
        check("rst_oe", bus_if.sda_oe, 0);
        check("rst_sda", bus_if.sda_out, 0);
        check("rst_busy", bus_if.busy, 0);
        rst = 1'b0;
        wait_clk(5);

        // Empty holding register after reset: 16 zeros with underrun.
        d_done = n_done; d_under = n_under;
        run_frame(8'h00, 16, 1'b1);
        check("empty_done", n_done - d_done, 1);
        check("empty_underrun", n_under - d_under, 1);

        // 8'hA5 frame.
        accept_byte(8'hA5);
        check("a5_ready_low", bus_if.sample_ready, 0);
        d_done = n_done; d_under = n_under;
        run_frame(8'hA5, 16, 1'b1);
        check("a5_done", n_done - d_done, 1);
        check("a5_no_underrun", n_under - d_under, 0);
        check("a5_ready_after", bus_if.sample_ready, 1);
        check("a5_idle_oe", bus_if.sda_oe, 0);

        // 3C, then 3C again as an underrun resend.
        accept_byte(8'h3C);
        d_under = n_under;
        run_frame(8'h3C, 16, 1'b1);
        check("3c_no_underrun", n_under - d_under, 0);
        d_under = n_under; d_done = n_done;
        run_frame(8'h3C, 16, 1'b1);
        check("3c_resend_underrun", n_under - d_under, 1);
        check("3c_resend_done", n_done - d_done, 1);

        // 8'h22 offered while full must be ignored.
        bus_if.sample_data = 8'h11;
        bus_if.sample_valid = 1'b1;
        wait_clk(1);
        bus_if.sample_data = 8'h22;
        wait_clk(5);
        bus_if.sample_valid = 1'b0;
        wait_clk(2);
        check("hold_ready_low", bus_if.sample_ready, 0);
        run_frame(8'h11, 16, 1'b1);

        // Abort after 7 falling edges.
        accept_byte(8'h5A);
        d_done = n_done; d_abort = n_abort;
        run_frame(8'h5A, 7, 1'b1);
        check("abort_pulse", n_abort - d_abort, 1);
        check("abort_no_done", n_done - d_done, 0);
        check("abort_busy", bus_if.busy, 0);
        check("abort_oe", bus_if.sda_oe, 0);
        check("abort_ready", bus_if.sample_ready, 1);

        // 20 scl cycles: resend of 5A, zeros after the 16th, one frame_done.
        d_done = n_done; d_under = n_under; d_abort = n_abort;
        run_frame(8'h5A, 20, 1'b0);
        check("long_oe_done", bus_if.sda_oe, 1);
        bus_if.ncs = 1'b1;
        wait_clk(10);
        check("long_done_once", n_done - d_done, 1);
        check("long_underrun", n_under - d_under, 1);
        check("long_no_abort", n_abort - d_abort, 0);

        // Reset at bit 9 with a byte waiting in the holding register.
        accept_byte(8'hC3);
        d_done = n_done; d_abort = n_abort;
        run_frame(8'hC3, 9, 1'b0);
        accept_byte(8'h77);
        check("pre_rst_ready", bus_if.sample_ready, 0);
        rst = 1'b1;
        bus_if.ncs = 1'b1;
        wait_clk(3);
        check("mid_rst_ready", bus_if.sample_ready, 1);
        check("mid_rst_oe", bus_if.sda_oe, 0);
        check("mid_rst_sda", bus_if.sda_out, 0);
        check("mid_rst_busy", bus_if.busy, 0);
        rst = 1'b0;
        wait_clk(10);
        check("mid_rst_no_abort", n_abort - d_abort, 0);
        check("mid_rst_no_done", n_done - d_done, 0);
        check("post_rst_idle", bus_if.busy, 0);

        // Last byte cleared by reset, then a clean full frame.
        d_under = n_under;
        run_frame(8'h00, 16, 1'b1);
        check("post_rst_underrun", n_under - d_under, 1);
        accept_byte(8'h96);
        d_done = n_done;
        run_frame(8'h96, 16, 1'b1);
        check("post_rst_done", n_done - d_done, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sensor_responder.md
SENSOR_RESPONDER -- requirements
Module: sensor_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of flip-flops in the ncs and scl input synchronizers (legal values 2..4).
REQ-002 The block SHALL have parameter LEAD_ZEROS, default 3, giving the number of zero bits sent before the data byte; the frame length is fixed at 16 bits.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ncs  input  1  chip select from the bus initiator, active-low, asynchronous to clk.
REQ-006 scl  input  1  serial clock from the initiator, asynchronous to clk.
REQ-007 sda_out  output  1  serial data value.
REQ-008 sda_oe  output  1  sda output enable; 1 = drive sda_out, 0 = release the line.
REQ-009 sample_data  input  8  next sample to transmit.
REQ-010 sample_valid  input  1  sample_data is valid.
REQ-011 sample_ready  output  1  holding register is empty and can accept a sample.
REQ-012 frame_done  output  1  one-cycle pulse when a full 16-bit frame has been shifted out.
REQ-013 frame_abort  output  1  one-cycle pulse when ncs deasserts before frame completion.
REQ-014 underrun  output  1  one-cycle pulse when a frame starts with the holding register empty.
REQ-015 busy  output  1  high while the state is ACTIVE or DONE.

Function
REQ-016 ncs and scl SHALL each pass through a SYNC_STAGES flip-flop synchronizer; all edge detection SHALL use the last two synchronized values.
REQ-017 Frame format, bit 0 first on the wire: LEAD_ZEROS zero bits, then sample bits 7..0 (MSB first), then zero bits up to bit 15.
REQ-018 The state machine SHALL have states IDLE, ACTIVE and DONE.
REQ-019 IDLE -> ACTIVE on a synchronized ncs falling edge. In the same cycle the frame shift register SHALL load from the holding register and the bit counter SHALL clear to 0.
REQ-020 In ACTIVE, each synchronized scl falling edge SHALL advance the shift register by one bit and increment the 5-bit bit counter.
REQ-021 sda_out SHALL present frame bit n while the bit counter equals n.
REQ-022 On the scl falling edge that takes the bit counter to 16, the block SHALL enter DONE and pulse frame_done for one cycle.
REQ-023 In DONE, sda_out SHALL be 0 and further scl edges SHALL be ignored. DONE -> IDLE on a synchronized ncs rising edge.
REQ-024 A synchronized ncs rising edge in ACTIVE SHALL move the block to IDLE and pulse frame_abort for one cycle; the holding register is not refilled by an aborted frame.
REQ-025 sda_oe SHALL be 1 exactly when the state is ACTIVE or DONE; sda_out SHALL be 0 in IDLE.
REQ-026 sample_ready SHALL be 1 while the holding register is empty. A sample is accepted in a cycle where sample_valid and sample_ready are both 1; sample_valid while ready=0 SHALL be ignored (no overwrite).
REQ-027 Loading a frame SHALL empty the holding register; sample_ready SHALL rise the cycle after the load.
REQ-028 If the holding register is empty at frame start, the block SHALL resend the last transmitted byte and pulse underrun.
REQ-029 If an accept and a frame-start load occur in the same cycle, the load SHALL use the previous holding contents (or the last byte if empty), and the newly accepted byte SHALL remain held.
REQ-030 scl edges in IDLE SHALL have no effect.

Reset
REQ-031 While rst=1: state=IDLE, bit counter=0, holding register empty with last-byte=8'h00, sample_ready=1, sda_oe=0, sda_out=0, frame_done=frame_abort=underrun=0, busy=0, and synchronizers set to ncs=1, scl=0.
REQ-032 rst asserted mid-frame SHALL abort without pulsing frame_abort; after release the block SHALL wait in IDLE for the next ncs falling edge.

Verification
REQ-033 Accept 8'hA5, then drive 16 scl cycles with a 50-clk period inside ncs low -> sampled on scl rising edges 000_10100101_00000, frame_done pulses once, sample_ready=1.
REQ-034 Drive a frame with no sample loaded after reset -> underrun pulse and 16 zero bits; load 8'h3C, then drive two frames -> 3C is sent, then 3C is sent again with underrun.
REQ-035 Deassert ncs after 7 scl falling edges -> frame_abort pulse, state IDLE, sda_oe=0, no frame_done.
REQ-036 Hold sample_valid with 8'h11 and then 8'h22 while ready=0 -> 8'h22 is ignored; the next frame carries 8'h11.
REQ-037 Drive 20 scl cycles in one ncs window -> frame_done after the 16th falling edge; sda_out=0 for the remaining edges; no second frame_done.
REQ-038 Assert rst at bit 9 -> all outputs reach their REQ-031 values, no frame_abort; the next full frame transmits correctly.
